// File: rtl/bw_sram_pkg.sv
// Shared types and helper functions for the byte-write SRAM front end.
// Contents:
//   size_e        - access size encoding (byte, half, word, illegal)
//   rsp_t         - one response entry (load data + error flag)
//   meta_t        - request attributes carried from the RAM strobe cycle
//                   to the RAM read-data cycle
//   is_misaligned - error detection for size/offset combinations
//   be_mask       - byte-lane enables for a given size and byte offset
//   align_wdata   - replicates store data onto every lane it might land in
//   extract_rdata - shifts the addressed lanes down and zero/sign extends
package bw_sram_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [1:0]  offset;
        size_e       size;
        logic        uns;
    } meta_t;

    // Halves must sit on an even byte, words on a word boundary, and the
    // fourth size code is never legal.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offset[0];
            SZ_W:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] be_mask(input size_e size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            SZ_B:    base = 4'b0001;
            SZ_H:    base = 4'b0011;
            SZ_W:    base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << offset;
    endfunction

    // Replicating the LSB-aligned data means the lane enables alone pick
    // the destination; no shifter is needed on the write path.
    function automatic logic [31:0] align_wdata(input size_e size, input logic [31:0] wdata);
        logic [31:0] out;
        case (size)
            SZ_B:    out = {4{wdata[7:0]}};
            SZ_H:    out = {2{wdata[15:0]}};
            default: out = wdata;
        endcase
        return out;
    endfunction

    function automatic logic [31:0] extract_rdata(input size_e size, input logic uns,
                                                  input logic [1:0] offset, input logic [31:0] raw);
        logic [31:0] shifted;
        logic [31:0] out;
        shifted = raw >> {offset, 3'b000};
        case (size)
            SZ_B:    out = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            SZ_H:    out = {{16{shifted[15] & ~uns}}, shifted[15:0]};
            default: out = shifted;
        endcase
        return out;
    endfunction

endpackage

// File: rtl/bw_sram_rsp_fifo.sv
// Response FIFO holding completed rsp_t entries until the consumer takes them.
// Storage is a flop array, so the head entry comes straight from registers.
// Pointers wrap at DEPTH, which need not be a power of two.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset (empties the FIFO)
//   push_i         - write push_data_i at the tail (never asserted when full)
//   push_data_i    - entry to store
//   pop_i          - drop the head entry (never asserted when empty)
//   head_o         - current head entry
//   valid_o        - FIFO holds at least one entry
//   count_o        - number of entries held
module bw_sram_rsp_fifo
    import bw_sram_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  rsp_t             push_data_i,
    input  logic             pop_i,
    output rsp_t             head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t             mem_q [DEPTH];
    rsp_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state logic: write the tail on push, advance the head on pop,
    // and leave the count alone when both happen in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers. Storage is cleared on reset too, so the head reads
    // as all-zero straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/bw_sram_ctrl.sv
// Request/response front end for a byte-write single-port RAM.
// Turns valid/ready byte-addressed loads and stores into RAM strobes. It
// aligns and extends load data and returns one in-order response per request.
// Ports:
//   clk_i, rst_i       - clock, asynchronous active-high reset
//   req_valid_i/ready_o - request handshake
//   req_addr_i         - byte address (ADDR_WIDTH+2 bits)
//   req_we_i           - 1 = store, 0 = load
//   req_size_i         - 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned_i     - load zero-extends when set, sign-extends otherwise
//   req_wdata_i        - LSB-aligned store data
//   rsp_valid_o/ready_i - response handshake
//   rsp_rdata_o        - aligned/extended load data, zero for stores and errors
//   rsp_err_o          - misaligned or illegal-size request
//   ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o - RAM strobes
//   ram_rdata_i        - RAM read data, valid the cycle after a read strobe
module bw_sram_ctrl
    import bw_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH+1:0] req_addr_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    size_e            req_size;
    logic             req_err;
    logic             fire;
    logic             pop;
    logic             pend_q, pend_d;
    logic             ready_en_q, ready_en_d;
    meta_t            meta_q, meta_d;
    rsp_t             push_data;
    rsp_t             head;
    logic             fifo_valid;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;

    assign req_size = size_e'(req_size_i);
    assign req_err  = is_misaligned(req_size, req_addr_i[1:0]);

    // A slot is reserved for every request in flight (pend) as well as every
    // stored response, so an accepted request always finds FIFO room. Only
    // registered terms feed ready, which keeps rsp_ready_i out of this path.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q};
    assign req_ready_o = ready_en_q && (credit_used < (CNT_W + 1)'(RSP_DEPTH));
    assign fire        = req_valid_i && req_ready_o;

    // Errored requests still take a pipeline slot and a response, but they
    // never strobe the RAM.
    assign ram_en_o    = fire && !req_err;
    assign ram_we_o    = req_we_i;
    assign ram_addr_o  = req_addr_i[ADDR_WIDTH+1:2];
    assign ram_be_o    = be_mask(req_size, req_addr_i[1:0]);
    assign ram_wdata_o = align_wdata(req_size, req_wdata_i);

    // Capture what the read-data cycle needs to shape the response. The
    // metadata only has to be loaded when a new request fires.
    always_comb begin
        pend_d     = fire;
        ready_en_d = 1'b1;
        meta_d     = meta_q;
        if (fire) begin
            meta_d.we     = req_we_i;
            meta_d.err    = req_err;
            meta_d.offset = req_addr_i[1:0];
            meta_d.size   = req_size;
            meta_d.uns    = req_unsigned_i;
        end
    end

    // The RAM read data is only meaningful for loads that actually reached
    // the RAM; everything else reports zero data.
    always_comb begin
        push_data.err   = meta_q.err;
        push_data.rdata = '0;
        if (!meta_q.we && !meta_q.err) begin
            push_data.rdata = extract_rdata(meta_q.size, meta_q.uns, meta_q.offset, ram_rdata_i);
        end
    end

    // Pipeline registers. ready_en_q holds off acceptance while reset is
    // asserted and opens on the first clock after it is released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q     <= 1'b0;
            ready_en_q <= 1'b0;
            meta_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            ready_en_q <= ready_en_d;
            meta_q     <= meta_d;
        end
    end

    assign pop = fifo_valid && rsp_ready_i;

    bw_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (pend_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign rsp_valid_o = fifo_valid;
    assign rsp_rdata_o = head.rdata;
    assign rsp_err_o   = head.err;

endmodule

// File: tb/tb_bw_sram_ctrl.sv
// Self-checking bench for bw_sram_ctrl paired with a behavioural byte-write RAM.
// A negedge monitor predicts each response from a shadow memory when a
// request is accepted and compares it when the response is consumed.
module tb_bw_sram_ctrl;
    import bw_sram_pkg::*;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_uns;
    logic [AW+1:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;

    int errors = 0;
    int checks = 0;
    int rsp_seen = 0;
    int stall_cycles = 0;
    logic        ram_load;
    logic [31:0] ram_mem [256];
    logic [31:0] shadow [256];
    rsp_t        exp_q [$];
    rsp_t        mon_exp;
    logic        acc_en;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        exp_en;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;
    vec_t vecs [15];

    always #5 clk = ~clk;

    bw_sram_ctrl #(.ADDR_WIDTH(AW), .RSP_DEPTH(3)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_be_o       (ram_be),
        .ram_rdata_i    (ram_rdata)
    );

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return {i, i ^ 8'hA5, i + 8'h3C, ~i};
    endfunction

    // Behavioural single-port RAM: lane writes, read data one cycle later.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(8'(i));
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    function automatic rsp_t model_rsp(input logic we, input logic [1:0] size, input logic uns,
                                       input logic [9:0] addr);
        rsp_t r;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        r.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        r.rdata = 32'h0;
        if (!r.err && !we) begin
            w = shadow[addr[9:2]];
            case (size)
                2'd0: begin
                    b = w[8*addr[1:0] +: 8];
                    r.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
                end
                2'd1: begin
                    h = addr[1] ? w[31:16] : w[15:0];
                    r.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
                end
                default: r.rdata = w;
            endcase
        end
        return r;
    endfunction

    function automatic void model_store(input logic [1:0] size, input logic [9:0] addr, input logic [31:0] wdata);
        case (size)
            2'd0: shadow[addr[9:2]][8*addr[1:0] +: 8] = wdata[7:0];
            2'd1: if (addr[1]) shadow[addr[9:2]][31:16] = wdata[15:0];
                  else         shadow[addr[9:2]][15:0]  = wdata[15:0];
            default: shadow[addr[9:2]] = wdata;
        endcase
    endfunction

    // Scoreboard monitor: push a prediction on every accepted request and
    // compare against the head on every consumed response.
    always @(negedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
        end else if (!rst) begin
            if (req_valid && req_ready) begin
                mon_exp = model_rsp(req_we, req_size, req_uns, req_addr);
                checkOutput("ram_en_on_fire", 32'(ram_en), 32'(!mon_exp.err));
                if (!mon_exp.err) begin
                    checkOutput("ram_addr", 32'(ram_addr), 32'(req_addr[9:2]));
                    checkOutput("ram_we", 32'(ram_we), 32'(req_we));
                end
                if (req_we && !mon_exp.err) model_store(req_size, req_addr, req_wdata);
                exp_q.push_back(mon_exp);
            end else begin
                checkOutput("ram_en_idle", 32'(ram_en), 32'h0);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got rsp 0x%08h, required no response", rsp_rdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, mon_exp.rdata);
                    checkOutput("rsp_err", 32'(rsp_err), 32'(mon_exp.err));
                end
            end
        end
    end

    // Drives one request and holds it until accepted; starts and ends just after a posedge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [9:0] addr, input logic [31:0] wdata);
        bit got = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (req_ready) begin
                got       = 1;
                acc_en    = ram_en;
                acc_be    = ram_be;
                acc_wdata = ram_wdata;
            end else begin
                stall_cycles++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept: got no handshake in 64 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d outstanding responses, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int accepted;
        int idx;
        bit any_valid;
        bit hs;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        1'b1, 4'b1111, 32'h0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 10'h013, 32'h00000080, 1'b1, 4'b1000, 32'h80808080};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 10'h013, 32'h0,        1'b1, 4'b1000, 32'h0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 10'h013, 32'h0,        1'b1, 4'b1000, 32'h0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 10'h022, 32'h1234C3A5, 1'b1, 4'b1100, 32'hC3A5C3A5};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 10'h022, 32'h0,        1'b1, 4'b1100, 32'h0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 10'h022, 32'h0,        1'b1, 4'b1100, 32'h0};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 10'h031, 32'hFFFFFF7F, 1'b1, 4'b0010, 32'h7F7F7F7F};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 10'h030, 32'h0,        1'b1, 4'b1111, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 10'h011, 32'h0,        1'b0, 4'b0000, 32'h0};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 10'h020, 32'h0,        1'b0, 4'b0000, 32'h0};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 10'h012, 32'h0,        1'b0, 4'b0000, 32'h0};
        vecs[13] = '{1'b0, 2'd1, 1'b0, 10'h010, 32'h0,        1'b1, 4'b0011, 32'h0};
        vecs[14] = '{1'b1, 2'd2, 1'b0, 10'h015, 32'h11223344, 1'b0, 4'b0000, 32'h0};

        rst = 1'b1; ram_load = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'h0);
        #1 ram_load = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_reset_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;

        // Table-driven single requests: strobes checked here, responses by the scoreboard.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_ram_en", i), 32'(acc_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                checkOutput($sformatf("vec%0d_ram_be", i), 32'(acc_be), 32'(vecs[i].exp_be));
                if (vecs[i].we)
                    checkOutput($sformatf("vec%0d_ram_wdata", i), acc_wdata, vecs[i].exp_wdata);
            end
        end
        waitDrain();

        // Load latency: response first visible two cycles after its handshake.
        applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
        @(negedge clk);
        checkOutput("latency_T1_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput("latency_T2_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk); #1;
        waitDrain();

        // Back-pressure: five word loads against a stalled consumer.
        rsp_ready = 1'b0;
        base = rsp_seen;
        accepted = 0;
        idx = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 10'h100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            hs = req_ready;
            @(posedge clk); #1;
            if (hs) begin
                accepted++;
                idx++;
                req_addr = 10'(32'h100 + 4 * idx);
            end
        end
        checkOutput("bp_accepted", 32'(accepted), 32'd3);
        @(negedge clk);
        checkOutput("bp_req_ready_low", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            @(negedge clk);
            hs = req_ready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                req_addr = 10'(32'h100 + 4 * idx);
            end
        end
        req_valid = 1'b0;
        waitDrain();
        checkOutput("bp_rsp_count", 32'(rsp_seen - base), 32'd5);

        // Streaming: 16 back-to-back loads with the consumer always ready.
        base = rsp_seen;
        stall_cycles = 0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 2'd2, 1'b0, 10'(32'h200 + 4 * i), 32'h0);
        checkOutput("stream_stalls", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("stream_rsp_count", 32'(rsp_seen - base), 32'd16);
        @(posedge clk); #1;
        waitDrain();

        // Reset with responses outstanding: everything in flight is dropped.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 2'd2, 1'b0, 10'h040, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 10'h044, 32'h0);
        @(negedge clk);
        checkOutput("pre_reset_rsp_valid", 32'(rsp_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("mid_reset_req_ready", 32'(req_ready), 32'h0);
        exp_q.delete();
        base = rsp_seen;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        any_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) any_valid = 1;
        end
        checkOutput("post_reset_no_stale_valid", 32'(any_valid), 32'h0);
        checkOutput("post_reset_rsp_count", 32'(rsp_seen - base), 32'd0);
        checkOutput("post_reset2_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
